// File: rtl/alu4_sequencer.sv
// Command-driven initiator for a 4-bit ALU: keeps an accumulator/carry, launches EXEC ops, captures results.
// Latency: response one cycle after accept (LOAD/READ/CLEAR), SETTLE_CYCLES+1 cycles after accept for EXEC.
// Backpressure: one command in flight; cmd_ready stays low until the response is taken by rsp_ready.
module alu4_sequencer #(
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W         = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [2:0] cmd_sel,
    input  logic [3:0] cmd_data,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [2:0] alu_select,
    input  logic [3:0] alu_out,
    input  logic       alu_carry,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [3:0] rsp_data,
    output logic       rsp_carry,
    output logic       busy
);

    localparam logic [1:0] OP_LOAD  = 2'd0;
    localparam logic [1:0] OP_EXEC  = 2'd1;
    localparam logic [1:0] OP_READ  = 2'd2;
    localparam logic [1:0] OP_CLEAR = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        RESPOND = 2'd2
    } state_t;

    state_t           state;
    logic [3:0]       acc;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            acc        <= 4'd0;
            carry      <= 1'b0;
            cnt        <= '0;
            alu_a      <= 4'd0;
            alu_b      <= 4'd0;
            alu_select <= 3'd0;
            rsp_valid  <= 1'b0;
            rsp_data   <= 4'd0;
            rsp_carry  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        case (cmd_op)
                            OP_LOAD: begin
                                acc       <= cmd_data;
                                carry     <= 1'b0;
                                rsp_data  <= cmd_data;
                                rsp_carry <= 1'b0;
                                rsp_valid <= 1'b1;
                                state     <= RESPOND;
                            end
                            OP_CLEAR: begin
                                acc       <= 4'd0;
                                carry     <= 1'b0;
                                rsp_data  <= 4'd0;
                                rsp_carry <= 1'b0;
                                rsp_valid <= 1'b1;
                                state     <= RESPOND;
                            end
                            OP_READ: begin
                                rsp_data  <= acc;
                                rsp_carry <= carry;
                                rsp_valid <= 1'b1;
                                state     <= RESPOND;
                            end
                            OP_EXEC: begin
                                alu_a      <= acc;
                                alu_b      <= cmd_data;
                                alu_select <= cmd_sel;
                                cnt        <= CNT_W'(SETTLE_CYCLES - 1);
                                state      <= SETTLE;
                            end
                            default: state <= IDLE;
                        endcase
                    end
                end
                SETTLE: begin
                    // ALU outputs are trusted only once the settle window has fully elapsed
                    if (cnt == '0) begin
                        acc       <= alu_out;
                        carry     <= alu_carry;
                        rsp_data  <= alu_out;
                        rsp_carry <= alu_carry;
                        rsp_valid <= 1'b1;
                        state     <= RESPOND;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESPOND: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu4_sequencer.sv
// Randomized and directed bench for alu4_sequencer against a behavioural accumulator model.
module tb_alu4_sequencer;

    localparam int S1 = 1;
    localparam int S3 = 3;
    localparam logic [1:0] LOAD = 2'd0, EXEC = 2'd1, READ = 2'd2, CLEAR = 2'd3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // main instance, SETTLE_CYCLES = 1, ideal adder as the ALU
    logic       cmd_valid = 1'b0, cmd_ready;
    logic [1:0] cmd_op = 2'd0;
    logic [2:0] cmd_sel = 3'd0;
    logic [3:0] cmd_data = 4'd0;
    logic [3:0] alu_a, alu_b, alu_out;
    logic [2:0] alu_select;
    logic       alu_carry;
    logic       rsp_valid, rsp_ready = 1'b0, rsp_carry, busy;
    logic [3:0] rsp_data;
    logic [4:0] alu_sum;

    assign alu_sum   = {1'b0, alu_a} + {1'b0, alu_b};
    assign alu_out   = alu_sum[3:0];
    assign alu_carry = alu_sum[4];

    alu4_sequencer #(.SETTLE_CYCLES(S1), .CNT_W(4)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_sel(cmd_sel), .cmd_data(cmd_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_select(alu_select),
        .alu_out(alu_out), .alu_carry(alu_carry),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_carry(rsp_carry), .busy(busy)
    );

    // second instance, SETTLE_CYCLES = 3, ALU outputs driven by hand
    logic       t3_cmd_valid = 1'b0, t3_cmd_ready;
    logic [1:0] t3_cmd_op = 2'd0;
    logic [2:0] t3_cmd_sel = 3'd0;
    logic [3:0] t3_cmd_data = 4'd0;
    logic [3:0] t3_alu_a, t3_alu_b, t3_alu_out = 4'hA;
    logic [2:0] t3_alu_select;
    logic       t3_alu_carry = 1'b1;
    logic       t3_rsp_valid, t3_rsp_ready = 1'b0, t3_rsp_carry, t3_busy;
    logic [3:0] t3_rsp_data;

    alu4_sequencer #(.SETTLE_CYCLES(S3), .CNT_W(4)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(t3_cmd_valid), .cmd_ready(t3_cmd_ready), .cmd_op(t3_cmd_op),
        .cmd_sel(t3_cmd_sel), .cmd_data(t3_cmd_data),
        .alu_a(t3_alu_a), .alu_b(t3_alu_b), .alu_select(t3_alu_select),
        .alu_out(t3_alu_out), .alu_carry(t3_alu_carry),
        .rsp_valid(t3_rsp_valid), .rsp_ready(t3_rsp_ready),
        .rsp_data(t3_rsp_data), .rsp_carry(t3_rsp_carry), .busy(t3_busy)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [3:0] ref_acc = 4'd0;
    logic       ref_carry = 1'b0;

    // Reference: accumulator semantics straight from the command definitions
    task automatic ref_apply(input logic [1:0] op, input logic [3:0] data);
        int s;
        case (op)
            LOAD:  begin ref_acc = data; ref_carry = 1'b0; end
            EXEC:  begin
                s = int'(ref_acc) + int'(data);
                ref_acc   = 4'(s % 16);
                ref_carry = (s >= 16);
            end
            CLEAR: begin ref_acc = 4'd0; ref_carry = 1'b0; end
            default: ;
        endcase
    endtask

    // Drive one command on the main instance; report edges from accept to rsp_valid and the response
    task automatic issue(input logic [1:0] op, input logic [2:0] sel, input logic [3:0] data,
                         output int lat, output logic [3:0] d, output logic c);
        int guard = 0;
        while (!cmd_ready && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        cmd_op = op; cmd_sel = sel; cmd_data = data; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_op = 2'($urandom); cmd_sel = 3'($urandom); cmd_data = 4'($urandom);
        lat = (guard >= 50) ? 99 : 0;
        while (!rsp_valid && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        d = rsp_data;
        c = rsp_carry;
    endtask

    task automatic take_rsp();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic t3_cmd(input logic [1:0] op, input logic [2:0] sel, input logic [3:0] data);
        int guard = 0;
        while (!t3_cmd_ready && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        t3_cmd_op = op; t3_cmd_sel = sel; t3_cmd_data = data; t3_cmd_valid = 1'b1;
        @(posedge clk); #1;
        t3_cmd_valid = 1'b0;
    endtask

    task automatic t3_take();
        t3_rsp_ready = 1'b1;
        @(posedge clk); #1;
        t3_rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        int lat; logic [3:0] d; logic c; logic [18:0] obs; int spurious = 0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        obs = {rsp_valid, rsp_data, rsp_carry, alu_a, alu_b, alu_select, busy, cmd_ready};
        n_checks++;
        if (obs !== 19'h1) $display("FAIL reset_state: got %h want %h", obs, 19'h1);
        else n_pass++;
        rst_n = 1'b1;
        ref_acc = 4'd0; ref_carry = 1'b0;
        ref_apply(LOAD, 4'h9);
        issue(LOAD, 3'd0, 4'h9, lat, d, c);
        take_rsp();
        // start an EXEC and reset while it is settling
        cmd_op = EXEC; cmd_sel = 3'd5; cmd_data = 4'h6; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || rsp_valid !== 1'b0)
            $display("FAIL reset_in_settle: busy=%b rsp_valid=%b want 1 0", busy, rsp_valid);
        else n_pass++;
        rst_n = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            if (rsp_valid) spurious++;
        end
        rst_n = 1'b1;
        obs = {rsp_valid, rsp_data, rsp_carry, alu_a, alu_b, alu_select, busy, cmd_ready};
        n_checks++;
        if (obs !== 19'h1) $display("FAIL reset_mid_exec: got %h want %h", obs, 19'h1);
        else n_pass++;
        repeat (3) begin
            @(posedge clk); #1;
            if (rsp_valid) spurious++;
        end
        n_checks++;
        if (spurious != 0) $display("FAIL reset_no_rsp: got %0d rsp_valid cycles want 0", spurious);
        else n_pass++;
        ref_acc = 4'd0; ref_carry = 1'b0;
        issue(READ, 3'd0, 4'h0, lat, d, c);
        n_checks++;
        if (lat != 0 || d !== 4'h0 || c !== 1'b0)
            $display("FAIL reset_first_cmd: lat=%0d d=%h c=%b want 0 0 0", lat, d, c);
        else n_pass++;
        take_rsp();
    endtask

    task automatic test_basic();
        int lat; logic [3:0] d; logic c;
        ref_apply(LOAD, 4'h5);
        issue(LOAD, 3'd0, 4'h5, lat, d, c);
        n_checks++;
        if (lat != 0 || d !== ref_acc || c !== ref_carry)
            $display("FAIL basic_load: lat=%0d d=%h c=%b want 0 %h %b", lat, d, c, ref_acc, ref_carry);
        else n_pass++;
        take_rsp();
        ref_apply(EXEC, 4'h3);
        issue(EXEC, 3'b010, 4'h3, lat, d, c);
        n_checks++;
        if (lat != S1 || d !== 4'h8 || c !== 1'b0 || d !== ref_acc)
            $display("FAIL basic_exec: lat=%0d d=%h c=%b want %0d 8 0", lat, d, c, S1);
        else n_pass++;
        n_checks++;
        if (alu_a !== 4'h5 || alu_b !== 4'h3 || alu_select !== 3'd2)
            $display("FAIL basic_alu_ins: a=%h b=%h sel=%h want 5 3 2", alu_a, alu_b, alu_select);
        else n_pass++;
        take_rsp();
    endtask

    task automatic test_overflow();
        int lat; logic [3:0] d; logic c;
        ref_apply(LOAD, 4'hF);
        issue(LOAD, 3'd0, 4'hF, lat, d, c);
        take_rsp();
        ref_apply(EXEC, 4'h1);
        issue(EXEC, 3'd7, 4'h1, lat, d, c);
        n_checks++;
        if (d !== 4'h0 || c !== 1'b1 || d !== ref_acc || c !== ref_carry)
            $display("FAIL overflow_exec: d=%h c=%b want 0 1", d, c);
        else n_pass++;
        take_rsp();
        issue(READ, 3'd0, 4'hC, lat, d, c);
        n_checks++;
        if (d !== 4'h0 || c !== 1'b1)
            $display("FAIL overflow_read: d=%h c=%b want 0 1", d, c);
        else n_pass++;
        take_rsp();
        ref_apply(LOAD, 4'h2);
        issue(LOAD, 3'd0, 4'h2, lat, d, c);
        n_checks++;
        if (d !== 4'h2 || c !== 1'b0)
            $display("FAIL overflow_load_clr_carry: d=%h c=%b want 2 0", d, c);
        else n_pass++;
        take_rsp();
    endtask

    task automatic test_backpressure();
        int lat; logic [3:0] d; logic c; logic [7:0] obs, exp_v;
        ref_apply(LOAD, 4'h3);
        issue(LOAD, 3'd0, 4'h3, lat, d, c);
        take_rsp();
        ref_apply(EXEC, 4'h4);
        issue(EXEC, 3'd1, 4'h4, lat, d, c);
        exp_v = {1'b1, ref_acc, ref_carry, 1'b0, 1'b1};
        cmd_op = CLEAR; cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            obs = {rsp_valid, rsp_data, rsp_carry, cmd_ready, busy};
            n_checks++;
            if (obs !== exp_v) $display("FAIL bp_hold_%0d: got %h want %h", i, obs, exp_v);
            else n_pass++;
        end
        cmd_valid = 1'b0;
        take_rsp();
        n_checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1)
            $display("FAIL bp_release: rsp_valid=%b cmd_ready=%b want 0 1", rsp_valid, cmd_ready);
        else n_pass++;
        // rsp_ready while idle must not matter; CLEAR offered during the stall must not have taken effect
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rsp_ready = 1'b0;
        issue(READ, 3'd0, 4'h0, lat, d, c);
        n_checks++;
        if (d !== ref_acc || c !== ref_carry || lat != 0)
            $display("FAIL bp_read_after: d=%h c=%b lat=%0d want %h %b 0", d, c, lat, ref_acc, ref_carry);
        else n_pass++;
        take_rsp();
    endtask

    task automatic test_back_to_back();
        int accepts = 0; int bad = 0; logic [3:0] last = 4'h0;
        rsp_ready = 1'b1; cmd_op = LOAD; cmd_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (rsp_valid && rsp_data !== last) bad++;
            cmd_data = 4'(accepts + 1);
            if (cmd_ready) begin
                accepts++;
                last = cmd_data;
            end
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        if (rsp_valid && rsp_data !== last) bad++;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        ref_apply(LOAD, last);
        n_checks++;
        if (accepts != 5) $display("FAIL b2b_throughput: got %0d accepts want 5", accepts);
        else n_pass++;
        n_checks++;
        if (bad != 0) $display("FAIL b2b_data: got %0d bad responses want 0", bad);
        else n_pass++;
    endtask

    task automatic test_random();
        int lat, stall, err_lat = 0, err_dat = 0, err_alu = 0, err_hold = 0;
        logic [1:0] op; logic [2:0] sel; logic [3:0] data, prev, d; logic c;
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3)); sel = 3'($urandom); data = 4'($urandom);
            prev = ref_acc;
            ref_apply(op, data);
            issue(op, sel, data, lat, d, c);
            if (lat != ((op == EXEC) ? S1 : 0)) err_lat++;
            if (d !== ref_acc || c !== ref_carry) err_dat++;
            if (op == EXEC && (alu_a !== prev || alu_b !== data || alu_select !== sel)) err_alu++;
            stall = $urandom_range(0, 3);
            repeat (stall) begin
                @(posedge clk); #1;
                if (!rsp_valid || rsp_data !== ref_acc) err_hold++;
            end
            take_rsp();
            if (rsp_valid || !cmd_ready) err_hold++;
        end
        n_checks++;
        if (err_lat != 0) $display("FAIL rand_latency: got %0d errors want 0", err_lat);
        else n_pass++;
        n_checks++;
        if (err_dat != 0) $display("FAIL rand_data: got %0d errors want 0", err_dat);
        else n_pass++;
        n_checks++;
        if (err_alu != 0) $display("FAIL rand_alu_ins: got %0d errors want 0", err_alu);
        else n_pass++;
        n_checks++;
        if (err_hold != 0) $display("FAIL rand_hold: got %0d errors want 0", err_hold);
        else n_pass++;
    endtask

    task automatic test_settle3();
        t3_alu_out = 4'hA; t3_alu_carry = 1'b1;
        t3_cmd(LOAD, 3'd0, 4'h4);
        n_checks++;
        if (t3_rsp_valid !== 1'b1 || t3_rsp_data !== 4'h4)
            $display("FAIL s3_load: v=%b d=%h want 1 4", t3_rsp_valid, t3_rsp_data);
        else n_pass++;
        t3_take();
        t3_cmd(EXEC, 3'b110, 4'h3);
        n_checks++;
        if (t3_alu_a !== 4'h4 || t3_alu_b !== 4'h3 || t3_alu_select !== 3'd6 || t3_busy !== 1'b1)
            $display("FAIL s3_alu_ins: a=%h b=%h sel=%h busy=%b want 4 3 6 1",
                     t3_alu_a, t3_alu_b, t3_alu_select, t3_busy);
        else n_pass++;
        repeat (2) begin @(posedge clk); #1; end
        n_checks++;
        if (t3_rsp_valid !== 1'b0) $display("FAIL s3_early: rsp_valid=%b want 0", t3_rsp_valid);
        else n_pass++;
        t3_alu_out = 4'h7; t3_alu_carry = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (t3_rsp_valid !== 1'b1 || t3_rsp_data !== 4'h7 || t3_rsp_carry !== 1'b0)
            $display("FAIL s3_capture: v=%b d=%h c=%b want 1 7 0", t3_rsp_valid, t3_rsp_data, t3_rsp_carry);
        else n_pass++;
        t3_take();
        t3_cmd(CLEAR, 3'd0, 4'h9);
        t3_take();
        t3_cmd(READ, 3'd0, 4'h5);
        n_checks++;
        if (t3_rsp_valid !== 1'b1 || t3_rsp_data !== 4'h0 || t3_rsp_carry !== 1'b0)
            $display("FAIL s3_clear_read: v=%b d=%h c=%b want 1 0 0", t3_rsp_valid, t3_rsp_data, t3_rsp_carry);
        else n_pass++;
        t3_take();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_settle3();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu4_sequencer.md
Name: alu4_sequencer

Overview:
- Command-driven initiator for the 4-bit ripple ALU: holds a 4-bit accumulator and carry flag, issues operand/select to the ALU, waits a settle time, captures result.
- Sits between a control source (valid/ready command stream) and an ALU instance; returns one response per command over a valid/ready response channel.
- ALU select codes are opaque to this block: passed through unchanged.

Parameters:
SETTLE_CYCLES, 1, clock edges between driving the ALU inputs and sampling alu_out/alu_carry; legal range 1..15.
CNT_W, 4, width of internal settle counter; must hold SETTLE_CYCLES.

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
cmd_valid  input  1  command present
cmd_ready  output  1  sequencer accepts command this cycle
cmd_op  input  2  0=LOAD, 1=EXEC, 2=READ, 3=CLEAR
cmd_sel  input  3  ALU select for EXEC
cmd_data  input  4  operand (LOAD value / EXEC b operand)
alu_a  output  4  ALU operand a (registered)
alu_b  output  4  ALU operand b (registered)
alu_select  output  3  ALU select (registered)
alu_out  input  4  ALU result
alu_carry  input  1  ALU carry_out
rsp_valid  output  1  response present
rsp_ready  input  1  consumer takes response
rsp_data  output  4  accumulator value after command
rsp_carry  output  1  carry flag after command
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (rst_n low at edge): state=IDLE, acc=0, carry=0, alu_a/alu_b/alu_select=0, rsp_valid=0, rsp_data=0, rsp_carry=0, counter=0. Reset wins over any handshake in the same cycle; an in-flight command is discarded, no response issued.
- States: IDLE, SETTLE, RESPOND.
- cmd_ready = (state==IDLE); combinational from state only, never from cmd_valid.
- Accept edge E0 = cmd_valid && cmd_ready.
- LOAD at E0: acc<=cmd_data, carry<=0, -> RESPOND.
- CLEAR at E0: acc<=0, carry<=0, -> RESPOND.
- READ at E0: acc/carry unchanged, -> RESPOND.
- EXEC at E0: alu_a<=acc, alu_b<=cmd_data, alu_select<=cmd_sel, counter<=SETTLE_CYCLES-1, -> SETTLE.
- SETTLE: counter decrements each edge; on edge where counter==0 (edge E0+SETTLE_CYCLES): acc<=alu_out, carry<=alu_carry, -> RESPOND.
- Entering RESPOND: rsp_valid<=1, rsp_data/rsp_carry loaded with the new acc/carry. Non-EXEC latency: rsp_valid high in cycle after E0. EXEC latency: rsp_valid high in cycle after E0+SETTLE_CYCLES.
- RESPOND: rsp_valid, rsp_data, rsp_carry held stable until rsp_valid && rsp_ready at an edge; then rsp_valid<=0, -> IDLE. cmd_ready rises the cycle after the response handshake (no same-cycle bypass); max throughput one command per 2 cycles (non-EXEC).
- rsp_ready asserted while rsp_valid low: ignored.
- alu_a/alu_b/alu_select change only on EXEC accept or reset; hold last values otherwise.
- Arithmetic: none internal; acc is exactly alu_out (4 bits), carry exactly alu_carry. No saturation; wrap is the ALU's.
- cmd_data/cmd_op/cmd_sel ignored when not accepted.

Test Plan:
- Bench ALU model: alu_out=(a+b)[3:0], alu_carry=(a+b)[4], checks alu_select==last EXEC cmd_sel.
- Reset: hold rst_n low 2 cycles mid-EXEC (in SETTLE) -> all outputs 0, state IDLE, no rsp_valid pulse; first cmd after release accepted normally.
- LOAD 4'h5, then EXEC data=4'h3 sel=3'b010 -> rsp_data=4'h8, rsp_carry=0, alu_a=5, alu_b=3, alu_select=2; rsp_valid exactly 1+SETTLE_CYCLES cycles after accept edge.
- Overflow: LOAD 4'hF, EXEC data=4'h1 -> rsp_data=4'h0, rsp_carry=1; then READ -> 0/1; then LOAD 4'h2 -> rsp_carry=0.
- Backpressure: rsp_ready low 5 cycles after EXEC response -> rsp_valid/rsp_data stable, cmd_ready low, busy high; raise rsp_ready -> handshake, cmd_ready high next cycle.
- SETTLE_CYCLES=3 build: bench ALU model returns garbage (4'hA) until 3rd edge then correct 4'h7 -> captured value 4'h7; CLEAR then READ -> rsp_data=0, rsp_carry=0.
